pipe_hold_ctrl: RTL and testbench

//  Parametrised pipeline hold/flush controller.
//  - Merges NUM_SRC hold requests, each carrying its own hold level, into one hold bus.
//  - Forwards jumps to pc_reg and applies a timed flush window after each jump.
//  - Buffers a jump that arrives while pc_reg is not ready, then releases it.
//  - Watchdog flags hold sources that stall the pipeline too long.
//  - Sits between ex/rib/clint/div (the hold sources) and pc_reg/if_id/id_ex.

---
 rtl/pipe_hold_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges source hold levels, forwards or buffers jumps,
// applies a flush window and watches for long stalls. Optional stall counter: PIPE_HOLD_CTRL_PERF_EN.
module pipe_hold_ctrl #(
  parameter int NUM_SRC      = 4,
  parameter int HOLD_W       = 3,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        hold_req_i,
  input  logic [NUM_SRC*HOLD_W-1:0] hold_lvl_i,
  input  logic                      jump_req_i,
  input  logic [ADDR_W-1:0]         jump_addr_i,
  input  logic                      pc_ready_i,
  output logic [HOLD_W-1:0]         hold_flag_o,
  output logic                      jump_flag_o,
  output logic [ADDR_W-1:0]         jump_addr_o,
  output logic                      flush_busy_o,
  output logic                      timeout_o,
  output logic [31:0]               stall_cnt_o
);
  localparam logic [HOLD_W-1:0] LVL_ID     = HOLD_W'(3);
  localparam int                WD_W       = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(HOLD_TIMEOUT);
  localparam logic [WD_W-1:0]   WD_FIRE    = WD_W'(HOLD_TIMEOUT - 1);
  localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_next;
  logic [3:0]          flush_cnt, flush_cnt_next;
  logic [WD_W-1:0]     wd_cnt, wd_cnt_next;
  logic [HOLD_W-1:0]   lvl_clamped [NUM_SRC];
  logic [HOLD_W-1:0]   src_lvl;
  logic [HOLD_W-1:0]   hold_c;
  logic                jump_c;
  logic [ADDR_W-1:0]   addr_c;
  logic                wd_active;
  logic                timeout_c;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clamp
      assign lvl_clamped[gi] = (hold_lvl_i[gi*HOLD_W +: HOLD_W] > LVL_ID) ? LVL_ID
                             : hold_lvl_i[gi*HOLD_W +: HOLD_W];
    end
  endgenerate

  always_comb begin
    src_lvl = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hold_req_i[k] && (lvl_clamped[k] > src_lvl)) src_lvl = lvl_clamped[k];
    end
  end

  always_comb begin
    state_next     = state;
    pend_addr_next = pend_addr;
    flush_cnt_next = flush_cnt;
    hold_c         = LVL_ID;
    jump_c         = 1'b0;
    addr_c         = '0;
    case (state)
      IDLE, FLUSH: begin
        if (jump_req_i) begin
          if (pc_ready_i) begin
            jump_c         = 1'b1;
            addr_c         = jump_addr_i;
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_INIT;
          end else begin
            pend_addr_next = jump_addr_i;
            state_next     = PEND;
            flush_cnt_next = '0;
          end
        end else if (state == FLUSH) begin
          // flush_cnt counts the flush cycles still owed, including this one
          if (flush_cnt <= 4'd1) begin
            flush_cnt_next = '0;
            state_next     = IDLE;
          end else begin
            flush_cnt_next = flush_cnt - 4'd1;
          end
        end else begin
          hold_c = src_lvl;
        end
      end
      PEND: begin
        if (pc_ready_i) begin
          jump_c         = 1'b1;
          addr_c         = jump_req_i ? jump_addr_i : pend_addr;
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_INIT;
        end else if (jump_req_i) begin
          pend_addr_next = jump_addr_i;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wd_active = (state == IDLE) && (src_lvl != '0);
    timeout_c = wd_active && (wd_cnt == WD_FIRE);
    if (!wd_active)         wd_cnt_next = '0;
    else if (wd_cnt == WD_MAX) wd_cnt_next = wd_cnt;
    else                    wd_cnt_next = wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend_addr <= '0;
      flush_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      state     <= state_next;
      pend_addr <= pend_addr_next;
      flush_cnt <= flush_cnt_next;
      wd_cnt    <= wd_cnt_next;
    end
  end

  // Combinational outputs are forced low while reset is asserted
  assign hold_flag_o  = rst ? hold_c : '0;
  assign jump_flag_o  = rst & jump_c;
  assign jump_addr_o  = rst ? addr_c : '0;
  assign flush_busy_o = rst & (state != IDLE);
  assign timeout_o    = rst & timeout_c;

`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((hold_flag_o != '0) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: directed scenarios plus random traffic,
// compared against a behavioural model of pending-jump / flush-window / hold-run rules.
module tb_pipe_hold_ctrl;
  localparam int NS = 4;
  localparam int HW = 3;
  localparam int AW = 32;
  localparam int FC = 2;
  localparam int TO = 8;
`ifdef PIPE_HOLD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [HW-1:0] hold;
    logic          jf;
    logic [AW-1:0] addr;
    logic          busy;
    logic          tmo;
    logic [31:0]   stall;
  } out_t;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    hold_req;
  logic [NS*HW-1:0] hold_lvl;
  logic             jump_req;
  logic [AW-1:0]    jump_addr;
  logic             pc_ready;
  logic [HW-1:0]    hold_flag;
  logic             jump_flag;
  logic [AW-1:0]    jump_addr_out;
  logic             flush_busy;
  logic             timeout;
  logic [31:0]      stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model state: a buffered jump, flush cycles still owed, length of current source-hold run
  bit          m_pend, n_pend;
  logic [31:0] m_pend_a, n_pend_a;
  int          m_flush, n_flush;
  int          m_run, n_run;
  longint      m_stalls, n_stalls;

  pipe_hold_ctrl #(
    .NUM_SRC(NS), .HOLD_W(HW), .ADDR_W(AW), .FLUSH_CYCLES(FC), .HOLD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .hold_req_i(hold_req), .hold_lvl_i(hold_lvl),
    .jump_req_i(jump_req), .jump_addr_i(jump_addr), .pc_ready_i(pc_ready),
    .hold_flag_o(hold_flag), .jump_flag_o(jump_flag), .jump_addr_o(jump_addr_out),
    .flush_busy_o(flush_busy), .timeout_o(timeout), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t observed();
    out_t o;
    o.hold = hold_flag; o.jf = jump_flag; o.addr = jump_addr_out;
    o.busy = flush_busy; o.tmo = timeout; o.stall = stall_cnt;
    return o;
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_pend_a = '0; m_flush = 0; m_run = 0; m_stalls = 0;
  endfunction

  function automatic out_t model_step();
    out_t        e;
    int          src, lv;
    bit          busy, issue;
    logic [31:0] ia;
    src = 0;
    for (int k = 0; k < NS; k++) begin
      if (hold_req[k]) begin
        lv = int'(hold_lvl[k*HW +: HW]);
        if (lv > 3) lv = 3;
        if (lv > src) src = lv;
      end
    end
    busy = m_pend || (m_flush > 0);
    n_pend = m_pend; n_pend_a = m_pend_a; n_flush = m_flush;
    issue = 0; ia = '0;
    if (m_pend) begin
      if (pc_ready) begin issue = 1; ia = jump_req ? jump_addr : m_pend_a; end
      else if (jump_req) n_pend_a = jump_addr;
    end else if (jump_req) begin
      if (pc_ready) begin issue = 1; ia = jump_addr; end
      else begin n_pend = 1; n_pend_a = jump_addr; n_flush = 0; end
    end else if (m_flush > 0) begin
      n_flush = m_flush - 1;
    end
    if (issue) begin n_pend = 0; n_flush = FC; end
    e.hold  = (busy || jump_req) ? HW'(3) : HW'(src);
    e.jf    = issue;
    e.addr  = ia;
    e.busy  = busy;
    e.tmo   = !busy && (src != 0) && (m_run == TO - 1);
    n_run   = (!busy && (src != 0)) ? m_run + 1 : 0;
    e.stall = PERF ? m_stalls[31:0] : 32'd0;
    n_stalls = m_stalls + ((e.hold != 0 && m_stalls < 64'hFFFF_FFFF) ? 1 : 0);
    return e;
  endfunction

  task automatic finish_cycle();
    @(posedge clk);
    m_pend = n_pend; m_pend_a = n_pend_a; m_flush = n_flush; m_run = n_run; m_stalls = n_stalls;
  endtask

  task automatic idle_inputs();
    hold_req = '0; hold_lvl = NS*HW'($urandom); jump_req = 0; jump_addr = $urandom; pc_ready = $urandom_range(0, 1);
  endtask

  task automatic test_reset();
    out_t obs;
    rst = 0; idle_inputs(); hold_req = 4'hF; jump_req = 1;
    #2;
    obs = observed(); vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_out got=%h want=0", obs); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = observed(); vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_hold got=%h want=0", obs); end
    idle_inputs(); rst = 1; model_reset();
    finish_cycle();
  endtask

  task automatic test_merge();
    out_t obs, exp;
    int   want_hold [6] = '{3, 1, 0, 3, 2, 0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      case (i)
        0: begin hold_req = 4'b0101; hold_lvl = {3'($urandom), 3'd3, 3'($urandom), 3'd1}; end
        1: begin hold_req = 4'b0001; hold_lvl = {3'($urandom), 3'd3, 3'($urandom), 3'd1}; end
        3: begin hold_req = 4'b1000; hold_lvl = {3'd6, 3'd0, 3'd0, 3'd0}; end
        4: begin hold_req = 4'b1010; hold_lvl = {3'd1, 3'd7, 3'd2, 3'd7}; end
        default: hold_req = '0;
      endcase
      if (i == 4) hold_req = 4'b1010;
      if (i == 4) hold_lvl = {3'd1, 3'd5, 3'd2, 3'd5};
      #1;
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL merge cyc=%0d got=%h want=%h", i, obs, exp); end
      vectors++;
      if (hold_flag !== HW'(want_hold[i])) begin
        miscompares++; $display("FAIL merge_level cyc=%0d got=%0d want=%0d", i, hold_flag, want_hold[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_jump_flush();
    out_t obs, exp;
    int   want_hold [5] = '{3, 3, 3, 2, 2};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      hold_req = 4'b0001; hold_lvl = {9'($urandom) & 9'h0, 3'd2};
      jump_req = (i == 0); jump_addr = (i == 0) ? 32'h80 : $urandom; pc_ready = 1;
      #1;
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL jump_flush cyc=%0d got=%h want=%h", i, obs, exp); end
      vectors++;
      if ({hold_flag, jump_flag, jump_addr_out} !== {HW'(want_hold[i]), i == 0, (i == 0) ? 32'h80 : 32'h0}) begin
        miscompares++;
        $display("FAIL jump_flush_seq cyc=%0d got hold=%0d jf=%0b addr=%h want hold=%0d", i, hold_flag, jump_flag, jump_addr_out, want_hold[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_pend();
    out_t obs, exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      pc_ready  = (i >= 4);
      jump_req  = (i == 0) || (i == 1);
      jump_addr = (i == 0) ? 32'h100 : (i == 1) ? 32'h200 : $urandom;
      #1;
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL pend cyc=%0d got=%h want=%h", i, obs, exp); end
      vectors++;
      if ({jump_flag, jump_addr_out} !== {i == 4, (i == 4) ? 32'h200 : 32'h0} || (i < 7 && hold_flag !== 3'd3)) begin
        miscompares++;
        $display("FAIL pend_seq cyc=%0d got jf=%0b addr=%h hold=%0d", i, jump_flag, jump_addr_out, hold_flag);
      end
      finish_cycle();
    end
  endtask

  task automatic test_back_to_back();
    out_t obs, exp;
    bit   want_busy [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      jump_req  = (i == 0) || (i == 1) || (i == 3);
      pc_ready  = (i != 3);
      jump_addr = 32'h300 + 32'(i) * 32'h40;
      #1;
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, obs, exp); end
      vectors++;
      if (flush_busy !== want_busy[i]) begin
        miscompares++; $display("FAIL b2b_busy cyc=%0d got=%0b want=%0b", i, flush_busy, want_busy[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_watchdog();
    out_t obs, exp;
    int   pulses, first_at;
    for (int pass = 0; pass < 2; pass++) begin
      pulses = 0; first_at = -1;
      for (int i = -2; i < 20; i++) begin
        @(negedge clk);
        idle_inputs();
        pc_ready = 1;
        if (i >= 0) begin
          hold_req = 4'b0010;
          hold_lvl = {3'($urandom), 3'($urandom_range(1, 7)), 3'($urandom)};
        end
        #1;
        exp = model_step(); obs = observed(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL watchdog pass=%0d cyc=%0d got=%h want=%h", pass, i, obs, exp); end
        if (timeout === 1'b1) begin pulses++; if (first_at < 0) first_at = i + 1; end
        finish_cycle();
      end
      vectors++;
      if (pulses !== 1 || first_at !== TO) begin
        miscompares++; $display("FAIL watchdog_pulse pass=%0d got count=%0d at=%0d want count=1 at=%0d", pass, pulses, first_at, TO);
      end
    end
  endtask

  task automatic test_random();
    out_t obs, exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      hold_req  = NS'($urandom);
      if ($urandom_range(0, 3) == 0) hold_req = '0;
      hold_lvl  = NS*HW'($urandom);
      jump_req  = ($urandom_range(0, 6) == 0);
      jump_addr = $urandom;
      pc_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp); end
      finish_cycle();
    end
  endtask

  task automatic test_reset_pend();
    out_t obs, exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_inputs();
      hold_req = 4'b0100; hold_lvl = {3'd0, 3'd2, 6'd0};
      jump_req = (i == 0); jump_addr = 32'h500; pc_ready = 0;
      #1;
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_pend_setup cyc=%0d got=%h want=%h", i, obs, exp); end
      if (i == 0) finish_cycle();
    end
    #2 rst = 0; pc_ready = 1;
    #1;
    obs = observed(); vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_pend_async got=%h want=0", obs); end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1; jump_req = 0; pc_ready = 1;
    #1;
    vectors++;
    if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_pend_stall got=%0d want=0", stall_cnt); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        jump_req = 0; pc_ready = 1; hold_req = '0;
        #1;
      end
      exp = model_step(); obs = observed(); vectors++;
      if (obs !== exp || jump_flag !== 1'b0) begin
        miscompares++; $display("FAIL reset_pend_after cyc=%0d got=%h want=%h", i, obs, exp);
      end
      finish_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout_guard simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    test_reset();
    test_merge();
    test_jump_flush();
    test_pend();
    test_back_to_back();
    test_watchdog();
    test_random();
    test_reset_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
